// File: rtl/mux_pkg.sv
// Shared types and defaults for the registered channel multiplexer.
package mux_pkg;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_RR     = 1'b1
    } mux_mode_t;

    localparam int MUX_N_DEFAULT = 5;
    localparam int MUX_W_DEFAULT = 1;

    // Channel-index width: clog2(n), but never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first requesting channel at or after ptr, wrapping.
module rr_pick
    import mux_pkg::*;
#(
    parameter  int N  = MUX_N_DEFAULT,
    localparam int SW = sel_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic          found,
    output logic [SW-1:0] grant
);

    localparam int unsigned NU = N;

    int unsigned p;
    int unsigned d;
    int unsigned best;

    // The channel with the smallest forward distance from ptr wins.
    always_comb begin
        found = 1'b0;
        grant = '0;
        p     = 32'(ptr);
        d     = 0;
        best  = NU;
        for (int unsigned k = 0; k < NU; k++) begin
            d = (k + NU - p) % NU;
            if (req[k] && (d < best)) begin
                best  = d;
                grant = SW'(k);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_reg.sv
// N-channel multiplexer with manual or round-robin selection and a registered
// single-beat output stage with ready/valid handshake.
module mux_rr_reg
    import mux_pkg::*;
#(
    parameter  int N  = MUX_N_DEFAULT,
    parameter  int W  = MUX_W_DEFAULT,
    localparam int SW = sel_width(N)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [SW-1:0]  out_chan,
    output logic           err,
    input  logic           err_clr
);

    mux_mode_t     mode_e;
    logic [SW-1:0] ptr;
    logic          rr_found;
    logic [SW-1:0] rr_grant;
    logic          load_slot;
    logic          sel_ok;
    logic          grant_ok;
    logic [SW-1:0] grant_idx;
    logic [W-1:0]  grant_data;
    logic          xfer;
    logic          bad_sel;
    logic [SW-1:0] ptr_wrap;

    rr_pick #(.N(N)) u_rr_pick (
        .req   (in_valid),
        .ptr   (ptr),
        .found (rr_found),
        .grant (rr_grant)
    );

    always_comb begin
        mode_e     = mux_mode_t'(mode);
        load_slot  = ~out_valid | out_ready;
        sel_ok     = int'(sel) < N;
        grant_ok   = 1'b0;
        grant_idx  = '0;
        grant_data = '0;
        in_ready   = '0;

        if (mode_e == MODE_RR) begin
            grant_ok  = rr_found;
            grant_idx = rr_grant;
        end else begin
            grant_idx = sel;
            // Out-of-range codes match no channel, so they never grant.
            for (int unsigned k = 0; k < N; k++) begin
                if (SW'(k) == sel) grant_ok = in_valid[k];
            end
        end

        for (int unsigned k = 0; k < N; k++) begin
            if (SW'(k) == grant_idx) grant_data = in_data[k*W +: W];
        end

        xfer    = reset_n & load_slot & grant_ok;
        bad_sel = (mode_e == MODE_MANUAL) & ~sel_ok & load_slot;

        for (int unsigned k = 0; k < N; k++) begin
            in_ready[k] = xfer && (SW'(k) == grant_idx);
        end

        ptr_wrap = (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_chan  <= '0;
            ptr       <= '0;
            err       <= 1'b0;
        end else begin
            if (xfer) begin
                out_data  <= grant_data;
                out_chan  <= grant_idx;
                out_valid <= 1'b1;
                if (mode_e == MODE_RR) ptr <= ptr_wrap;
            end else if (bad_sel) begin
                out_data  <= '0;
                out_valid <= 1'b0;
            end else if (load_slot) begin
                out_valid <= 1'b0;
            end

            if (bad_sel)      err <= 1'b1;
            else if (err_clr) err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_rr_reg.sv
// Self-checking bench for mux_rr_reg: directed table, corner sequences, random vs model.
module tb_mux_rr_reg;
    import mux_pkg::*;

    localparam int N  = 5;
    localparam int W  = 8;
    localparam int SW = 3;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           mode;
    logic [SW-1:0]  sel;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic [SW-1:0]  out_chan;
    logic           err;
    logic           err_clr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux_rr_reg #(.N(N), .W(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_chan  (out_chan),
        .err       (err),
        .err_clr   (err_clr)
    );

    localparam logic [N*W-1:0] DATA = {8'h5E, 8'hA5, 8'h3C, 8'h2B, 8'h1A};

    typedef struct {
        logic       md;
        logic [2:0] sl;
        logic [4:0] iv;
        logic       ordy;
        logic       clr;
        logic [4:0] ir;
        logic       ov;
        logic [7:0] od;
        logic [2:0] oc;
        logic       er;
    } vec_t;

    vec_t vt[10];

    // Reference model state
    int       m_ov, m_oc, m_ptr, m_err;
    logic [7:0] m_od;

    function automatic logic [7:0] chan_data(input int c);
        logic [N*W-1:0] d;
        d = DATA;
        return d[c*8 +: 8];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic m, input logic [2:0] s, input logic [4:0] iv,
                         input logic ordy, input logic clr);
        mode      = m;
        sel       = s;
        in_valid  = iv;
        out_ready = ordy;
        err_clr   = clr;
    endtask

    task automatic apply_vec(input int idx, input vec_t v);
        drive(v.md, v.sl, v.iv, v.ordy, v.clr);
        #3;
        check($sformatf("vec%0d.in_ready", idx), 64'(in_ready), 64'(v.ir));
        @(posedge clk); #1;
        check($sformatf("vec%0d.out_valid", idx), 64'(out_valid), 64'(v.ov));
        check($sformatf("vec%0d.out_data", idx), 64'(out_data), 64'(v.od));
        check($sformatf("vec%0d.out_chan", idx), 64'(out_chan), 64'(v.oc));
        check($sformatf("vec%0d.err", idx), 64'(err), 64'(v.er));
    endtask

    task automatic rr_step(input string tag, input logic [4:0] iv, input logic ordy,
                           input logic [4:0] exp_ir, input logic exp_ov, input int exp_oc);
        drive(1'b1, 3'd0, iv, ordy, 1'b0);
        #3;
        check({tag, ".in_ready"}, 64'(in_ready), 64'(exp_ir));
        @(posedge clk); #1;
        check({tag, ".out_valid"}, 64'(out_valid), 64'(exp_ov));
        check({tag, ".out_chan"}, 64'(out_chan), 64'(exp_oc));
        check({tag, ".out_data"}, 64'(out_data), 64'(chan_data(exp_oc)));
    endtask

    // Spec-level decision: which channel (if any) is accepted this cycle.
    task automatic model_pick(output int gch, output bit badsel);
        bit load;
        int c;
        load   = (m_ov == 0) || out_ready;
        gch    = -1;
        badsel = 0;
        if (load) begin
            if (mode == 1'b0) begin
                if (int'(sel) < N) begin
                    if (in_valid[sel]) gch = int'(sel);
                end else begin
                    badsel = 1;
                end
            end else begin
                for (int j = 0; j < N; j++) begin
                    c = (m_ptr + j) % N;
                    if (gch < 0 && in_valid[c]) gch = c;
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rr_exp[7];
        int gch;
        bit badsel;
        bit load;
        logic [4:0] exp_ir;
        logic [N*W-1:0] dcopy;

        rr_exp = '{0, 1, 2, 3, 4, 0, 1};

        vt[0] = '{1'b0, 3'd3, 5'b01000, 1'b1, 1'b0, 5'b01000, 1'b1, 8'hA5, 3'd3, 1'b0};
        vt[1] = '{1'b0, 3'd6, 5'b11111, 1'b1, 1'b0, 5'b00000, 1'b0, 8'h00, 3'd3, 1'b1};
        vt[2] = '{1'b0, 3'd0, 5'b00000, 1'b1, 1'b1, 5'b00000, 1'b0, 8'h00, 3'd3, 1'b0};
        vt[3] = '{1'b0, 3'd1, 5'b00010, 1'b0, 1'b0, 5'b00010, 1'b1, 8'h2B, 3'd1, 1'b0};
        vt[4] = '{1'b0, 3'd2, 5'b00100, 1'b0, 1'b0, 5'b00000, 1'b1, 8'h2B, 3'd1, 1'b0};
        vt[5] = '{1'b0, 3'd7, 5'b00000, 1'b0, 1'b0, 5'b00000, 1'b1, 8'h2B, 3'd1, 1'b0};
        vt[6] = '{1'b0, 3'd7, 5'b00000, 1'b1, 1'b1, 5'b00000, 1'b0, 8'h00, 3'd1, 1'b1};
        vt[7] = '{1'b0, 3'd5, 5'b00000, 1'b1, 1'b0, 5'b00000, 1'b0, 8'h00, 3'd1, 1'b1};
        vt[8] = '{1'b0, 3'd4, 5'b10000, 1'b1, 1'b1, 5'b10000, 1'b1, 8'h5E, 3'd4, 1'b0};
        vt[9] = '{1'b1, 3'd0, 5'b00000, 1'b1, 1'b0, 5'b00000, 1'b0, 8'h5E, 3'd4, 1'b0};

        reset_n = 1'b0;
        in_data = DATA;
        drive(1'b0, 3'd0, 5'b11111, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.out_data", 64'(out_data), 64'd0);
        check("rst.out_chan", 64'(out_chan), 64'd0);
        check("rst.err", 64'(err), 64'd0);
        check("rst.in_ready", 64'(in_ready), 64'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) apply_vec(i, vt[i]);

        // Round-robin scan from ptr=0 with every channel requesting
        for (int i = 0; i < 7; i++) begin
            exp_ir = 5'd1 << rr_exp[i];
            rr_step($sformatf("rr%0d", i), 5'b11111, 1'b1, exp_ir, 1'b1, rr_exp[i]);
        end
        // ptr=2: only ch0 requests -> grant 0, ptr becomes 1
        rr_step("rr_set1", 5'b00001, 1'b1, 5'b00001, 1'b1, 0);
        rr_step("rr_wrap4", 5'b10001, 1'b1, 5'b10000, 1'b1, 4);
        rr_step("rr_wrap0", 5'b10001, 1'b1, 5'b00001, 1'b1, 0);
        // ptr=1, out_valid=1 on ch0: stall for three cycles
        for (int i = 0; i < 3; i++)
            rr_step($sformatf("bp%0d", i), 5'b11111, 1'b0, 5'b00000, 1'b1, 0);
        rr_step("bp_release", 5'b11111, 1'b1, 5'b00010, 1'b1, 1);

        // Asynchronous reset mid-beat
        drive(1'b0, 3'd6, 5'b00000, 1'b1, 1'b0);
        @(posedge clk); #1;
        check("ar.err_set", 64'(err), 64'd1);
        drive(1'b0, 3'd2, 5'b00100, 1'b1, 1'b0);
        @(posedge clk); #1;
        check("ar.beat_valid", 64'(out_valid), 64'd1);
        check("ar.beat_data", 64'(out_data), 64'h3C);
        drive(1'b0, 3'd2, 5'b11111, 1'b1, 1'b0);
        #1;
        reset_n = 1'b0;
        #1;
        check("ar.out_valid", 64'(out_valid), 64'd0);
        check("ar.out_data", 64'(out_data), 64'd0);
        check("ar.out_chan", 64'(out_chan), 64'd0);
        check("ar.err", 64'(err), 64'd0);
        check("ar.in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        rr_step("ar.ptr0", 5'b11111, 1'b1, 5'b00001, 1'b1, 0);

        // Randomized run against the reference model
        @(posedge clk); #1;
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        m_ov = 0; m_od = '0; m_oc = 0; m_ptr = 0; m_err = 0;
        for (int i = 0; i < 400; i++) begin
            mode      = 1'($urandom_range(0, 1));
            sel       = 3'($urandom_range(0, 7));
            in_valid  = 5'($urandom);
            in_data   = {8'($urandom), 32'($urandom)};
            out_ready = ($urandom_range(0, 3) != 0);
            err_clr   = ($urandom_range(0, 7) == 0);
            #3;
            model_pick(gch, badsel);
            exp_ir = (gch >= 0) ? (5'd1 << gch) : 5'd0;
            check($sformatf("rnd%0d.in_ready", i), 64'(in_ready), 64'(exp_ir));
            load  = (m_ov == 0) || out_ready;
            dcopy = in_data;
            @(posedge clk);
            if (gch >= 0) begin
                m_ov = 1;
                m_od = dcopy[gch*8 +: 8];
                m_oc = gch;
                if (mode) m_ptr = (gch + 1) % N;
            end else if (badsel) begin
                m_ov = 0;
                m_od = '0;
            end else if (load) begin
                m_ov = 0;
            end
            if (badsel) m_err = 1;
            else if (err_clr) m_err = 0;
            #1;
            check($sformatf("rnd%0d.out_valid", i), 64'(out_valid), 64'(m_ov));
            check($sformatf("rnd%0d.out_data", i), 64'(out_data), 64'(m_od));
            check($sformatf("rnd%0d.out_chan", i), 64'(out_chan), 64'(m_oc));
            check($sformatf("rnd%0d.err", i), 64'(err), 64'(m_err));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
